// File: rtl/iram_access_ctrl.sv
// CPU-side initiator for the 8051 internal RAM/SFR block: serialises byte and
// bit requests into byte-mode read / write strobes, doing bit ops as read-modify-write.
module iram_access_ctrl #(
  parameter int ADDRESS_WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     req_valid,
  output logic                     req_ready,
  input  logic [2:0]               req_op,
  input  logic [ADDRESS_WIDTH-1:0] req_addr,
  input  logic [7:0]               req_wdata,
  input  logic                     req_wbit,
  output logic                     rsp_valid,
  output logic [7:0]               rsp_data,
  output logic                     rsp_bit,
  output logic                     rsp_err,
  output logic [ADDRESS_WIDTH-1:0] mem_addr,
  output logic                     mem_rd,
  output logic                     mem_wr,
  output logic [7:0]               mem_wdata,
  input  logic [7:0]               mem_rdata
);

  localparam logic [2:0] OP_RD_BYTE  = 3'd0;
  localparam logic [2:0] OP_WR_BYTE  = 3'd1;
  localparam logic [2:0] OP_RD_BIT   = 3'd2;
  localparam logic [2:0] OP_WR_BIT   = 3'd3;
  localparam logic [2:0] OP_CPL_BIT  = 3'd4;
  localparam logic [2:0] OP_INC_BYTE = 3'd5;
  localparam logic [2:0] OP_DEC_BYTE = 3'd6;
  localparam logic [2:0] OP_RSVD     = 3'd7;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_RD   = 3'd1,
    S_CAP  = 3'd2,
    S_WR   = 3'd3,
    S_RSP  = 3'd4
  } state_t;

  state_t                   state_q, state_d;
  logic [2:0]               op_q, op_d;
  logic [2:0]               idx_q, idx_d;
  logic                     wbit_q, wbit_d;
  logic [ADDRESS_WIDTH-1:0] mem_addr_q, mem_addr_d;
  logic [7:0]               mem_wdata_q, mem_wdata_d;
  logic                     mem_rd_q, mem_rd_d;
  logic                     mem_wr_q, mem_wr_d;
  logic                     req_ready_q, req_ready_d;
  logic                     rsp_valid_q, rsp_valid_d;
  logic [7:0]               rsp_data_q, rsp_data_d;
  logic                     rsp_bit_q, rsp_bit_d;
  logic                     rsp_err_q, rsp_err_d;

  logic [ADDRESS_WIDTH-1:0] bit_byte_addr;
  logic                     req_is_bit;
  logic                     op_is_bit;
  logic [7:0]               bit_mask;
  logic [7:0]               mod_byte;

  // Bit addresses 00-7F map onto bytes 20h-2Fh; 80-FF select SFRs at multiples of 8.
  always_comb begin
    if (req_addr[ADDRESS_WIDTH-1]) begin
      bit_byte_addr = {req_addr[ADDRESS_WIDTH-1:3], 3'b000};
    end else begin
      bit_byte_addr = ADDRESS_WIDTH'(8'h20) + ADDRESS_WIDTH'(req_addr[6:3]);
    end
  end

  assign req_is_bit = (req_op == OP_RD_BIT) || (req_op == OP_WR_BIT) || (req_op == OP_CPL_BIT);
  assign op_is_bit  = (op_q == OP_RD_BIT) || (op_q == OP_WR_BIT) || (op_q == OP_CPL_BIT);
  assign bit_mask   = 8'b1 << idx_q;

  always_comb begin
    mod_byte = mem_rdata;
    case (op_q)
      OP_WR_BIT:   mod_byte = wbit_q ? (mem_rdata | bit_mask) : (mem_rdata & ~bit_mask);
      OP_CPL_BIT:  mod_byte = mem_rdata ^ bit_mask;
      OP_INC_BYTE: mod_byte = mem_rdata + 8'd1;
      OP_DEC_BYTE: mod_byte = mem_rdata - 8'd1;
      default:     mod_byte = mem_rdata;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    op_d        = op_q;
    idx_d       = idx_q;
    wbit_d      = wbit_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    rsp_data_d  = rsp_data_q;
    rsp_bit_d   = rsp_bit_q;
    rsp_err_d   = rsp_err_q;

    case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          op_d       = req_op;
          idx_d      = req_addr[2:0];
          wbit_d     = req_wbit;
          mem_addr_d = req_is_bit ? bit_byte_addr : req_addr;
          case (req_op)
            OP_WR_BYTE: begin
              state_d     = S_WR;
              mem_wdata_d = req_wdata;
            end
            OP_RSVD: begin
              state_d    = S_RSP;
              rsp_data_d = 8'h00;
              rsp_bit_d  = 1'b0;
              rsp_err_d  = 1'b1;
            end
            default: state_d = S_RD;
          endcase
        end
      end
      S_RD: state_d = S_CAP;
      S_CAP: begin
        // mem_rdata is valid now, one cycle after the read strobe.
        if ((op_q == OP_RD_BYTE) || (op_q == OP_RD_BIT)) begin
          state_d    = S_RSP;
          rsp_data_d = mem_rdata;
          rsp_bit_d  = (op_q == OP_RD_BIT) ? mem_rdata[idx_q] : 1'b0;
          rsp_err_d  = 1'b0;
        end else begin
          state_d     = S_WR;
          mem_wdata_d = mod_byte;
        end
      end
      S_WR: begin
        state_d    = S_RSP;
        rsp_data_d = mem_wdata_q;
        rsp_bit_d  = op_is_bit ? mem_wdata_q[idx_q] : 1'b0;
        rsp_err_d  = 1'b0;
      end
      S_RSP:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    // Strobes and flags are registered copies of the next state.
    mem_rd_d    = (state_d == S_RD);
    mem_wr_d    = (state_d == S_WR);
    rsp_valid_d = (state_d == S_RSP);
    req_ready_d = (state_d == S_IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      op_q        <= OP_RD_BYTE;
      idx_q       <= 3'd0;
      wbit_q      <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= 8'h00;
      mem_rd_q    <= 1'b0;
      mem_wr_q    <= 1'b0;
      req_ready_q <= 1'b1;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= 8'h00;
      rsp_bit_q   <= 1'b0;
      rsp_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      op_q        <= op_d;
      idx_q       <= idx_d;
      wbit_q      <= wbit_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      mem_rd_q    <= mem_rd_d;
      mem_wr_q    <= mem_wr_d;
      req_ready_q <= req_ready_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
      rsp_bit_q   <= rsp_bit_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

  assign req_ready = req_ready_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_data  = rsp_data_q;
  assign rsp_bit   = rsp_bit_q;
  assign rsp_err   = rsp_err_q;
  assign mem_addr  = mem_addr_q;
  assign mem_rd    = mem_rd_q;
  assign mem_wr    = mem_wr_q;
  assign mem_wdata = mem_wdata_q;

endmodule

// File: tb/tb_iram_access_ctrl.sv
// Bench for iram_access_ctrl: byte-wide RAM, shadow-memory reference model checked
// every cycle, plus directed scenarios with literal expectations.
module tb_iram_access_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       req_valid;
  logic       req_ready;
  logic [2:0] req_op;
  logic [7:0] req_addr;
  logic [7:0] req_wdata;
  logic       req_wbit;
  logic       rsp_valid;
  logic [7:0] rsp_data;
  logic       rsp_bit;
  logic       rsp_err;
  logic [7:0] mem_addr;
  logic       mem_rd;
  logic       mem_wr;
  logic [7:0] mem_wdata;
  logic [7:0] mem_rdata;

  always #5 clk = ~clk;

  iram_access_ctrl #(.ADDRESS_WIDTH(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_op    (req_op),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .req_wbit  (req_wbit),
    .rsp_valid (rsp_valid),
    .rsp_data  (rsp_data),
    .rsp_bit   (rsp_bit),
    .rsp_err   (rsp_err),
    .mem_addr  (mem_addr),
    .mem_rd    (mem_rd),
    .mem_wr    (mem_wr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata)
  );

  // RAM with registered read; backdoor port used to preload contents.
  logic [7:0] ram [256];
  logic [7:0] ram_rdata = 8'h00;
  logic       bd_we = 1'b0;
  logic [7:0] bd_addr = 8'h00;
  logic [7:0] bd_data = 8'h00;

  always @(posedge clk) begin
    if (bd_we) ram[bd_addr] <= bd_data;
    else if (mem_wr) ram[mem_addr] <= mem_wdata;
    if (mem_rd) ram_rdata <= ram[mem_addr];
  end
  assign mem_rdata = ram_rdata;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] bit_byte(input logic [7:0] a);
    int ai;
    ai = int'(a);
    if (ai < 128) return 8'(32 + ai / 8);
    return 8'((ai / 8) * 8);
  endfunction

  // Reference model state
  logic [7:0] ref_mem [256];
  bit         armed = 1'b0;
  bit         pending = 1'b0;
  int         cnt = 0;
  int         m_lat = 0;
  bit         m_reads, m_writes, m_chkbit, m_err;
  logic [7:0] m_addr, m_data;
  logic       m_bit;
  int         n_rsp = 0;
  int         last_lat = 0;
  logic [7:0] last_data = 8'h00;
  logic       last_bit = 1'b0;
  logic       last_err = 1'b0;

  always @(negedge clk) begin
    if (bd_we) ref_mem[bd_addr] = bd_data;
    if (!rst_n) begin
      pending = 1'b0;
    end else if (armed) begin
      if (pending) begin
        cnt++;
        chk("mem_rd", mem_rd, (m_reads && cnt == 1));
        chk("mem_wr", mem_wr, (m_writes && cnt == m_lat - 1));
        chk("req_ready_busy", req_ready, 1'b0);
        if ((m_reads && cnt == 1) || (m_writes && cnt == m_lat - 1))
          chk("mem_addr", mem_addr, m_addr);
        if (m_writes && cnt == m_lat - 1) chk("mem_wdata", mem_wdata, m_data);
        chk("rsp_valid", rsp_valid, (cnt == m_lat));
        if (cnt == m_lat) begin
          chk("rsp_data", rsp_data, m_data);
          chk("rsp_err", rsp_err, m_err);
          if (m_chkbit) chk("rsp_bit", rsp_bit, m_bit);
          if (m_writes) ref_mem[m_addr] = m_data;
          last_lat  = cnt;
          last_data = rsp_data;
          last_bit  = rsp_bit;
          last_err  = rsp_err;
          n_rsp++;
          pending = 1'b0;
        end
      end else begin
        chk("idle_mem_rd", mem_rd, 1'b0);
        chk("idle_mem_wr", mem_wr, 1'b0);
        chk("idle_rsp_valid", rsp_valid, 1'b0);
        chk("idle_req_ready", req_ready, 1'b1);
      end
      // A handshake happens at the coming rising edge.
      if (req_valid && req_ready) begin
        logic [7:0] b, nb;
        int idx;
        chk("two_in_flight", pending, 1'b0);
        idx      = int'(req_addr) % 8;
        m_addr   = (req_op inside {3'd2, 3'd3, 3'd4}) ? bit_byte(req_addr) : req_addr;
        b        = ref_mem[m_addr];
        nb       = b;
        m_reads  = 1'b1;
        m_writes = 1'b1;
        m_chkbit = 1'b0;
        m_err    = 1'b0;
        m_bit    = 1'b0;
        m_lat    = 4;
        case (req_op)
          3'd0: begin m_data = b; m_writes = 1'b0; m_lat = 3; end
          3'd1: begin m_data = req_wdata; m_reads = 1'b0; m_lat = 2; end
          3'd2: begin m_data = b; m_bit = b[idx]; m_chkbit = 1'b1; m_writes = 1'b0; m_lat = 3; end
          3'd3: begin nb[idx] = req_wbit; m_data = nb; m_bit = nb[idx]; m_chkbit = 1'b1; end
          3'd4: begin nb[idx] = ~b[idx]; m_data = nb; m_bit = nb[idx]; m_chkbit = 1'b1; end
          3'd5: m_data = 8'((int'(b) + 1) % 256);
          3'd6: m_data = 8'((int'(b) + 255) % 256);
          default: begin
            m_data = 8'h00; m_err = 1'b1; m_chkbit = 1'b1;
            m_reads = 1'b0; m_writes = 1'b0; m_lat = 1;
          end
        endcase
        pending = 1'b1;
        cnt = 0;
      end
    end
  end

  task automatic set_ram(input logic [7:0] a, input logic [7:0] d);
    @(posedge clk); #1;
    bd_we = 1'b1; bd_addr = a; bd_data = d;
    @(posedge clk); #1;
    bd_we = 1'b0;
  endtask

  task automatic send(input logic [2:0] op, input logic [7:0] a, input logic [7:0] wd,
                      input logic wb, input bit wait_rsp);
    @(posedge clk); #1;
    req_op = op; req_addr = a; req_wdata = wd; req_wbit = wb; req_valid = 1'b1;
    for (int i = 0; i < 20 && !req_ready; i++) begin
      @(posedge clk); #1;
    end
    @(posedge clk); #1;
    // Scramble inputs while busy; they must be ignored.
    req_valid = 1'b0; req_op = 3'd0; req_addr = a ^ 8'h55; req_wdata = ~wd; req_wbit = ~wb;
    if (wait_rsp) begin
      repeat (6) @(posedge clk);
      #1;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int n0;
    rst_n = 1'b0; req_valid = 1'b0; req_op = 3'd0; req_addr = 8'h00;
    req_wdata = 8'h00; req_wbit = 1'b0;
    for (int i = 0; i < 256; i++) begin
      @(posedge clk); #1;
      bd_we = 1'b1; bd_addr = 8'(i); bd_data = 8'((i * 37 + 11) % 256);
    end
    @(posedge clk); #1;
    bd_we = 1'b0;

    chk("rst_req_ready", req_ready, 1'b1);
    chk("rst_rsp_valid", rsp_valid, 1'b0);
    chk("rst_rsp_data", rsp_data, 8'h00);
    chk("rst_rsp_bit", rsp_bit, 1'b0);
    chk("rst_rsp_err", rsp_err, 1'b0);
    chk("rst_mem_addr", mem_addr, 8'h00);
    chk("rst_mem_rd", mem_rd, 1'b0);
    chk("rst_mem_wr", mem_wr, 1'b0);
    chk("rst_mem_wdata", mem_wdata, 8'h00);
    chk("decode_e7", bit_byte(8'hE7), 8'hE0);
    chk("decode_0b", bit_byte(8'h0B), 8'h21);
    chk("decode_7f", bit_byte(8'h7F), 8'h2F);

    rst_n = 1'b1;
    armed = 1'b1;

    // Reset during WR of WR_BYTE 40h <- AA
    set_ram(8'h40, 8'h11);
    n0 = n_rsp;
    send(3'd1, 8'h40, 8'hAA, 1'b0, 1'b0);
    chk("midwr_mem_wr_high", mem_wr, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    chk("midwr_mem_wr_drop", mem_wr, 1'b0);
    chk("midwr_ready", req_ready, 1'b1);
    chk("midwr_rsp_valid", rsp_valid, 1'b0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    chk("midwr_ram40", ram[8'h40], 8'h11);
    chk("midwr_no_rsp", n_rsp - n0, 0);

    send(3'd1, 8'h30, 8'h5A, 1'b0, 1'b1);
    chk("wrbyte_lat", last_lat, 2);
    chk("wrbyte_data", last_data, 8'h5A);
    chk("wrbyte_ram30", ram[8'h30], 8'h5A);
    send(3'd0, 8'h30, 8'h00, 1'b0, 1'b1);
    chk("rdbyte_lat", last_lat, 3);
    chk("rdbyte_data", last_data, 8'h5A);
    chk("rdbyte_err", last_err, 1'b0);

    set_ram(8'h21, 8'h00);
    send(3'd3, 8'h0B, 8'h00, 1'b1, 1'b1);
    chk("wrbit_lat", last_lat, 4);
    chk("wrbit_bit", last_bit, 1'b1);
    chk("wrbit_data", last_data, 8'h08);
    chk("wrbit_ram21", ram[8'h21], 8'h08);
    send(3'd2, 8'h0B, 8'h00, 1'b0, 1'b1);
    chk("rdbit_bit", last_bit, 1'b1);
    chk("rdbit_lat", last_lat, 3);

    set_ram(8'hE0, 8'h80);
    send(3'd4, 8'hE7, 8'h00, 1'b0, 1'b1);
    chk("cpl_lat", last_lat, 4);
    chk("cpl_bit", last_bit, 1'b0);
    chk("cpl_ramE0", ram[8'hE0], 8'h00);

    set_ram(8'h7F, 8'hFF);
    send(3'd5, 8'h7F, 8'h00, 1'b0, 1'b1);
    chk("inc_data", last_data, 8'h00);
    chk("inc_err", last_err, 1'b0);
    send(3'd6, 8'h7F, 8'h00, 1'b0, 1'b1);
    chk("dec_data", last_data, 8'hFF);
    chk("dec_ram7F", ram[8'h7F], 8'hFF);

    send(3'd7, 8'h12, 8'h34, 1'b1, 1'b1);
    chk("rsvd_lat", last_lat, 1);
    chk("rsvd_err", last_err, 1'b1);
    chk("rsvd_data", last_data, 8'h00);

    // req_valid held high: one reserved request every two cycles.
    n0 = n_rsp;
    @(posedge clk); #1;
    req_op = 3'd7; req_valid = 1'b1;
    repeat (10) @(posedge clk);
    #1 req_valid = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    chk("held_valid_count", n_rsp - n0, 5);

    // Mixed traffic against the model.
    for (int i = 0; i < 24; i++) begin
      logic [2:0] op;
      op = 3'($urandom_range(0, 7));
      send(op, 8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)),
           1'($urandom_range(0, 1)), 1'b1);
    end
    for (int a = 0; a < 256; a++) begin
      if (ram[a] !== ref_mem[a]) chk("ram_final", ram[a], ref_mem[a]);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
